// File: rtl/alu_ctrl_pkg.sv
// Shared types for the ALU op sequencer: opcode encodings, ALU control
// codes and the op-class used to pick single- or multi-cycle handling.
package alu_ctrl_pkg;

   localparam logic [4:0] OP_ADD  = 5'b11000;
   localparam logic [4:0] OP_JMP  = 5'b00001;
   localparam logic [4:0] OP_JEQ  = 5'b00111;
   localparam logic [4:0] OP_JGT  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b11010;
   localparam logic [4:0] OP_CMPR = 5'b10110;
   localparam logic [4:0] OP_CMPI = 5'b10111;
   localparam logic [4:0] OP_MUL  = 5'b11110;
   localparam logic [4:0] OP_MOD  = 5'b11100;
   localparam logic [4:0] OP_LSR  = 5'b11001;
   localparam logic [4:0] OP_MOVI = 5'b10101;
   localparam logic [4:0] OP_MOVR = 5'b10100;

   typedef enum logic [2:0] {
      ALU_ADD  = 3'b000,
      ALU_SUB  = 3'b001,
      ALU_MUL  = 3'b010,
      ALU_MOD  = 3'b011,
      ALU_LSR  = 3'b100,
      ALU_MOVI = 3'b101,
      ALU_NONE = 3'b111
   } alu_ctrl_e;

   typedef enum logic [1:0] {
      CLS_SINGLE,
      CLS_MUL,
      CLS_MOD,
      CLS_ILLEGAL
   } op_class_e;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode decode: alu_ctrl, branch/compare flags, op class.
// Ports: opcode (OPC_W, >=5) in; alu_ctrl, is_branch, is_cmp, op_class out.
module alu_op_decode
   import alu_ctrl_pkg::*;
#(
   parameter int OPC_W = 5
) (
   input  logic [OPC_W-1:0] opcode,
   output alu_ctrl_e        alu_ctrl,
   output logic             is_branch,
   output logic             is_cmp,
   output op_class_e        op_class
);

   logic [4:0] low;
   logic       upper_zero;

   assign low        = opcode[4:0];
   // Any set bit above the 5-bit encoding makes the opcode unknown.
   assign upper_zero = ((opcode >> 5) == '0);

   always_comb begin
      alu_ctrl  = ALU_NONE;
      is_branch = 1'b0;
      is_cmp    = 1'b0;
      op_class  = CLS_ILLEGAL;
      if (upper_zero) begin
         unique case (low)
            OP_ADD: begin
               alu_ctrl = ALU_ADD;
               op_class = CLS_SINGLE;
            end
            OP_JMP, OP_JEQ, OP_JGT: begin
               alu_ctrl  = ALU_ADD;
               is_branch = 1'b1;
               op_class  = CLS_SINGLE;
            end
            OP_SUB: begin
               alu_ctrl = ALU_SUB;
               op_class = CLS_SINGLE;
            end
            OP_CMPR, OP_CMPI: begin
               alu_ctrl = ALU_SUB;
               is_cmp   = 1'b1;
               op_class = CLS_SINGLE;
            end
            OP_MUL: begin
               alu_ctrl = ALU_MUL;
               op_class = CLS_MUL;
            end
            OP_MOD: begin
               alu_ctrl = ALU_MOD;
               op_class = CLS_MOD;
            end
            OP_LSR: begin
               alu_ctrl = ALU_LSR;
               op_class = CLS_SINGLE;
            end
            OP_MOVI: begin
               alu_ctrl = ALU_MOVI;
               op_class = CLS_SINGLE;
            end
            OP_MOVR: begin
               alu_ctrl = ALU_NONE;
               op_class = CLS_SINGLE;
            end
            default: begin
               alu_ctrl = ALU_NONE;
               op_class = CLS_ILLEGAL;
            end
         endcase
      end
   end

endmodule

// File: rtl/alu_op_sequencer.sv
// Registered opcode -> ALU control sequencer with valid/ready handshake;
// MUL/MOD are held for MUL_CYCLES/MOD_CYCLES before out_valid.
// Ports: clk, rst_n (async low), flush, in_valid/in_ready/opcode,
//   out_valid/out_ready, alu_ctrl, is_branch, is_cmp, busy.
// Option ALU_ILLEGAL_TRAP_EN: unknown opcodes are swallowed and
//   signalled on an extra illegal_op pulse output.
module alu_op_sequencer
   import alu_ctrl_pkg::*;
#(
   parameter int OPC_W      = 5,
   parameter int MUL_CYCLES = 3,
   parameter int MOD_CYCLES = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OPC_W-1:0] opcode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [2:0]       alu_ctrl,
   output logic             is_branch,
   output logic             is_cmp,
   output logic             busy
`ifdef ALU_ILLEGAL_TRAP_EN
   ,
   output logic             illegal_op
`endif
);

   localparam int MAX_C = max_int(MUL_CYCLES, MOD_CYCLES);
   localparam int CNT_W = $clog2(MAX_C + 1);

   localparam logic [CNT_W-1:0] MUL_M1 = CNT_W'(MUL_CYCLES - 1);
   localparam logic [CNT_W-1:0] MOD_M1 = CNT_W'(MOD_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_HOLD
   } state_e;

   state_e           state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [CNT_W-1:0] load_m1;

   alu_ctrl_e dec_ctrl;
   logic      dec_br;
   logic      dec_cmp;
   op_class_e dec_cls;

   alu_ctrl_e ctrl_q;
   logic      br_q;
   logic      cmp_q;
   logic      ill_q;

   logic accept;
   logic trap;
   logic issue;

   alu_op_decode #(
      .OPC_W (OPC_W)
   ) u_dec (
      .opcode    (opcode),
      .alu_ctrl  (dec_ctrl),
      .is_branch (dec_br),
      .is_cmp    (dec_cmp),
      .op_class  (dec_cls)
   );

   always_comb begin
      in_ready = (state == S_IDLE) |
                 ((state == S_HOLD) & out_ready);
      accept   = in_valid & in_ready & ~flush;
`ifdef ALU_ILLEGAL_TRAP_EN
      trap     = accept & (dec_cls == CLS_ILLEGAL);
`else
      trap     = 1'b0;
`endif
      issue    = accept & ~trap;

      // Extra WAIT cycles for the accepted op; zero means single-cycle.
      unique case (dec_cls)
         CLS_MUL: load_m1 = MUL_M1;
         CLS_MOD: load_m1 = MOD_M1;
         default: load_m1 = '0;
      endcase

      state_n = state;
      cnt_n   = cnt;
      unique case (state)
         S_IDLE, S_HOLD: begin
            if (issue) begin
               if (load_m1 != '0) begin
                  state_n = S_WAIT;
                  cnt_n   = load_m1;
               end else begin
                  state_n = S_HOLD;
               end
            end else if (state == S_HOLD) begin
               // A trapped accept from HOLD also consumes the held op.
               if (out_ready) state_n = S_IDLE;
            end
         end
         S_WAIT: begin
            if (cnt <= CNT_W'(1)) begin
               state_n = S_HOLD;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt - CNT_W'(1);
            end
         end
         default: begin
            state_n = S_IDLE;
            cnt_n   = '0;
         end
      endcase

      if (flush) begin
         state_n = S_IDLE;
         cnt_n   = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         cnt    <= '0;
         ctrl_q <= ALU_NONE;
         br_q   <= 1'b0;
         cmp_q  <= 1'b0;
         ill_q  <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         ill_q <= trap;
         if (issue) begin
            ctrl_q <= dec_ctrl;
            br_q   <= dec_br;
            cmp_q  <= dec_cmp;
         end
      end
   end

   assign out_valid = (state == S_HOLD);
   assign busy      = (state == S_WAIT);
   assign alu_ctrl  = ctrl_q;
   assign is_branch = br_q;
   assign is_cmp    = cmp_q;

`ifdef ALU_ILLEGAL_TRAP_EN
   assign illegal_op = ill_q;
`else
   logic unused_ill;
   assign unused_ill = ill_q;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomised bench for alu_op_sequencer against a transaction-level
// reference (op timestamps + decode table).
module tb_alu_op_sequencer;

   localparam int OPC_W = 5;
   localparam int MUL_C = 3;
   localparam int MOD_C = 8;
`ifdef ALU_ILLEGAL_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             flush = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [OPC_W-1:0] opcode = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [2:0]       alu_ctrl;
   logic             is_branch;
   logic             is_cmp;
   logic             busy;
   logic             illegal_op;

   int total = 0;
   int bad   = 0;

   // reference model state
   bit         has_op;
   int         ready_at;
   int         cyc;
   logic [2:0] m_ctrl;
   bit         m_br;
   bit         m_cmp;
   bit         m_ill;

   alu_op_sequencer #(
      .OPC_W      (OPC_W),
      .MUL_CYCLES (MUL_C),
      .MOD_CYCLES (MOD_C)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .opcode    (opcode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .alu_ctrl  (alu_ctrl),
      .is_branch (is_branch),
      .is_cmp    (is_cmp),
      .busy      (busy)
`ifdef ALU_ILLEGAL_TRAP_EN
      ,
      .illegal_op (illegal_op)
`endif
   );

`ifndef ALU_ILLEGAL_TRAP_EN
   assign illegal_op = 1'b0;
`endif

   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h (cyc %0d)",
                  tag, got, exp, cyc);
      end
   endtask

   function automatic void ref_dec(input logic [4:0] op,
                                   output logic [2:0] c,
                                   output bit br,
                                   output bit cm,
                                   output int lat,
                                   output bit ill);
      br = 0; cm = 0; lat = 1; ill = 0;
      case (op)
         5'b11000: c = 3'b000;
         5'b00001, 5'b00111, 5'b00011: begin c = 3'b000; br = 1; end
         5'b11010: c = 3'b001;
         5'b10110, 5'b10111: begin c = 3'b001; cm = 1; end
         5'b11110: begin c = 3'b010; lat = MUL_C; end
         5'b11100: begin c = 3'b011; lat = MOD_C; end
         5'b11001: c = 3'b100;
         5'b10101: c = 3'b101;
         5'b10100: c = 3'b111;
         default:  begin c = 3'b111; ill = 1; end
      endcase
   endfunction

   task automatic step(input bit iv, input logic [4:0] op,
                       input bit ordy, input bit fl);
      bit ev, eb, er, acc, br, cm, ill;
      logic [2:0] c;
      int lat;
      @(negedge clk);
      in_valid = iv; opcode = op; out_ready = ordy; flush = fl;
      #1;
      ev = has_op && (cyc >= ready_at);
      eb = has_op && (cyc < ready_at);
      er = !has_op || (ev && ordy);
      check("out_valid", 32'(out_valid), 32'(ev));
      check("busy", 32'(busy), 32'(eb));
      check("in_ready", 32'(in_ready), 32'(er));
      check("alu_ctrl", 32'(alu_ctrl), 32'(m_ctrl));
      check("is_branch", 32'(is_branch), 32'(m_br));
      check("is_cmp", 32'(is_cmp), 32'(m_cmp));
      if (TRAP) check("illegal_op", 32'(illegal_op), 32'(m_ill));
      acc = iv && er && !fl;
      ref_dec(op, c, br, cm, lat, ill);
      @(posedge clk);
      m_ill = 0;
      if (fl) begin
         has_op = 0;
      end else if (acc) begin
         if (TRAP && ill) begin
            has_op = 0;
            m_ill  = 1;
         end else begin
            has_op   = 1;
            ready_at = cyc + lat;
            m_ctrl   = c;
            m_br     = br;
            m_cmp    = cm;
         end
      end else if (ev && ordy) begin
         has_op = 0;
      end
      cyc++;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 0; in_valid = 0; flush = 0; out_ready = 0;
      #1;
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_alu_ctrl", 32'(alu_ctrl), 32'h7);
      check("rst_is_branch", 32'(is_branch), 0);
      check("rst_is_cmp", 32'(is_cmp), 0);
      if (TRAP) check("rst_illegal_op", 32'(illegal_op), 0);
      has_op = 0; m_ctrl = 3'b111; m_br = 0; m_cmp = 0; m_ill = 0;
      @(negedge clk);
      rst_n = 1;
   endtask

   logic [4:0] known [12] = '{
      5'b11000, 5'b00001, 5'b00111, 5'b00011, 5'b11010, 5'b10110,
      5'b10111, 5'b11110, 5'b11100, 5'b11001, 5'b10101, 5'b10100
   };

   initial begin
      logic [4:0] op;
      cyc = 0; ready_at = 0;
      do_reset();

      // ADD, single cycle
      step(1, 5'b11000, 1, 0);
      step(0, 5'b00000, 1, 0);
      step(0, 5'b00000, 1, 0);

      // MUL, multi-cycle
      step(1, 5'b11110, 1, 0);
      repeat (4) step(0, 5'b00000, 1, 0);

      // streamed JEQ, SUB, CMPI
      step(1, 5'b00111, 1, 0);
      step(1, 5'b11010, 1, 0);
      step(1, 5'b10111, 1, 0);
      repeat (2) step(0, 5'b00000, 1, 0);

      // backpressure in HOLD
      step(1, 5'b11010, 0, 0);
      repeat (4) step(1, 5'b11001, 0, 0);
      step(1, 5'b11001, 1, 0);
      repeat (2) step(0, 5'b00000, 1, 0);

      // flush during MOD
      step(1, 5'b11100, 1, 0);
      step(0, 5'b00000, 1, 0);
      step(0, 5'b00000, 1, 1);
      repeat (10) step(0, 5'b00000, 1, 0);

      // unknown opcode
      step(1, 5'b01010, 1, 0);
      repeat (3) step(0, 5'b00000, 1, 0);

      // reset in the middle of MOD
      step(1, 5'b11100, 1, 0);
      repeat (2) step(0, 5'b00000, 1, 0);
      do_reset();
      repeat (3) step(0, 5'b00000, 1, 0);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 9) < 7)
            op = known[$urandom_range(0, 11)];
         else
            op = 5'($urandom);
         step(bit'($urandom_range(0, 2) != 0), op,
              bit'($urandom_range(0, 3) != 0),
              bit'($urandom_range(0, 19) == 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
